// File: rtl/debug_loader_ctrl_if.sv
// debug_loader_ctrl_if: UART FIFO, CPU control and IMEM write bus between the loader and its neighbours.
interface debug_loader_ctrl_if #(
    parameter int NB_PC           = 32,
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int NB_UART_DATA    = 9,
    parameter int NB_UART_ADDR    = 5
);
    logic [NB_UART_DATA-1:0]    uart_rx_data;
    logic                       uart_rx_done;
    logic                       uart_rd;
    logic                       uart_wr;
    logic [NB_UART_DATA-1:0]    uart_wdata;
    logic [NB_UART_ADDR-1:0]    uart_wsize;
    logic                       uart_tx_start;
    logic                       uart_tx_done;
    logic                       cpu_en;
    logic                       cpu_halt;
    logic [NB_PC-1:0]           cpu_pc;
    logic                       imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] imem_waddr;
    logic [NB_INSTRUCTION-1:0]  imem_wdata;

    modport master (
        input  uart_rx_data, uart_rx_done, uart_tx_done, cpu_halt, cpu_pc,
        output uart_rd, uart_wr, uart_wdata, uart_wsize, uart_tx_start, cpu_en,
               imem_we, imem_waddr, imem_wdata
    );
    modport slave (
        output uart_rx_data, uart_rx_done, uart_tx_done, cpu_halt, cpu_pc,
        input  uart_rd, uart_wr, uart_wdata, uart_wsize, uart_tx_start, cpu_en,
               imem_we, imem_waddr, imem_wdata
    );
endinterface

// File: rtl/debug_loader_ctrl.sv
// debug_loader_ctrl: UART byte-command sequencer that loads IMEM, runs/steps the CPU and replies ACK/NAK/PC.
// Define DEBUG_TIMEOUT_EN to abort a stalled LOAD with NAK after TIMEOUT_CYCLES idle cycles.
module debug_loader_ctrl #(
    parameter int NB_PC           = 32,
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int NB_UART_DATA    = 9,
    parameter int NB_UART_ADDR    = 5,
    parameter int TIMEOUT_CYCLES  = 2**20
) (
    input logic                 clk,
    input logic                 rst_n,
    debug_loader_ctrl_if.master bus
);
    localparam int MAXW = 2**(IMEM_ADDR_WIDTH-2);
    localparam int PCW  = NB_PC < 32 ? NB_PC : 32;

    typedef enum logic [3:0] {
        IDLE, LOAD_LEN, LOAD_DATA, LOAD_WR, RUN, STEP, STEP_LATCH, TX_PUSH, TX_START, TX_WAIT
    } state_t;

    state_t      state, state_next;
    logic        skip, accept, timeout, loading, ack, nak, rep, cpu_en, unused_bits;
    logic [7:0]  rx_byte, n_words, k;
    logic [1:0]  bc, idx;
    logic [2:0]  len;
    logic [31:0] word, resp, pc32;

    assign rx_byte     = bus.uart_rx_data[7:0];
    assign pc32        = 32'(bus.cpu_pc[PCW-1:0]);
    assign loading     = state == LOAD_LEN || state == LOAD_DATA;
    // skip blanks the cycle after a pop while the RX FIFO head updates
    assign accept      = (state == IDLE || loading) && bus.uart_rx_done && !skip && !timeout;
    assign unused_bits = ^bus.uart_rx_data[NB_UART_DATA-1:8];

`ifdef DEBUG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] idle_cnt;
    always_ff @(posedge clk)
        idle_cnt <= (!rst_n || !loading || accept) ? '0 : idle_cnt + 1'b1;
    assign timeout = loading && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        ack        = 1'b0;
        nak        = 1'b0;
        rep        = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (rx_byte == 8'h4C) state_next = LOAD_LEN;
                else if (rx_byte == 8'h52) begin
                    if (bus.cpu_halt) rep = 1'b1;
                    else state_next = RUN;
                end
                else if (rx_byte == 8'h53) state_next = STEP;
                else nak = 1'b1;
            end
            LOAD_LEN: if (timeout) nak = 1'b1;
                else if (accept) begin
                    if (rx_byte == 8'd0 || int'(rx_byte) > MAXW) nak = 1'b1;
                    else state_next = LOAD_DATA;
                end
            LOAD_DATA:  if (timeout) nak = 1'b1; else if (accept && bc == 2'd3) state_next = LOAD_WR;
            LOAD_WR:    if (k == n_words - 8'd1) ack = 1'b1; else state_next = LOAD_DATA;
            RUN:        if (bus.cpu_halt) rep = 1'b1;
            STEP:       state_next = STEP_LATCH;
            STEP_LATCH: rep = 1'b1;
            TX_PUSH:    if ({1'b0, idx} == len - 3'd1) state_next = TX_START;
            TX_START:   state_next = TX_WAIT;
            TX_WAIT:    if (bus.uart_tx_done) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        if (ack || nak || rep) state_next = TX_PUSH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            skip    <= 1'b1;
            cpu_en  <= 1'b0;
            n_words <= '0;
            k       <= '0;
            bc      <= '0;
            idx     <= '0;
            len     <= '0;
            word    <= '0;
            resp    <= '0;
        end else begin
            state  <= state_next;
            skip   <= accept;
            cpu_en <= state_next == RUN || state_next == STEP;
            if (state == LOAD_LEN && accept) begin
                n_words <= rx_byte;
                k       <= '0;
                bc      <= '0;
            end
            if (state == LOAD_DATA && accept) begin
                word[8*bc +: 8] <= rx_byte;
                bc              <= bc + 2'd1;
            end
            if (state == LOAD_WR) k <= k + 8'd1;
            if (ack || nak || rep) begin
                resp <= rep ? pc32 : {24'd0, ack ? 8'h06 : 8'h15};
                len  <= rep ? 3'd4 : 3'd1;
                idx  <= '0;
            end
            if (state == TX_PUSH) idx <= idx + 2'd1;
        end
    end

    assign bus.cpu_en        = cpu_en;
    assign bus.uart_rd       = accept;
    assign bus.uart_wr       = state == TX_PUSH;
    assign bus.uart_wdata    = state == TX_PUSH ? NB_UART_DATA'(resp[8*idx +: 8]) : '0;
    assign bus.uart_tx_start = state == TX_START;
    assign bus.uart_wsize    = state == TX_START ? NB_UART_ADDR'(len) : '0;
    assign bus.imem_we       = state == LOAD_WR;
    assign bus.imem_waddr    = state == LOAD_WR ? IMEM_ADDR_WIDTH'({k, 2'b00}) : '0;
    assign bus.imem_wdata    = state == LOAD_WR ? NB_INSTRUCTION'(word) : '0;
endmodule
